// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave.
// Decodes address phases, inserts WAIT_STATES wait cycles in OKAY data phases,
// performs little-endian byte/halfword/word accesses into an internal array,
// and answers illegal accesses with the two-cycle ERROR response.
// Only DATA_WIDTH = 32 (four byte lanes) is supported.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int                  IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
    localparam logic [3:0]          WAIT_INIT  = 4'(WAIT_STATES);
    localparam bit                  HAS_WAIT   = (WAIT_STATES > 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Byte-lane enables for a little-endian access of the given size.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] mask;
        case (size)
            3'd0:    mask = 4'b0001 << lo;
            3'd1:    mask = lo[1] ? 4'b1100 : 4'b0011;
            3'd2:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Illegal size, misaligned access or address past the end of the array.
    function automatic logic access_err(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size);
        logic bad_size;
        logic misalign;
        logic out_of_range;
        bad_size     = (size > 3'd2);
        misalign     = ((size == 3'd1) && addr[0]) ||
                       ((size == 3'd2) && (addr[1:0] != 2'b00));
        out_of_range = ({1'b0, addr} >= BYTE_LIMIT);
        return bad_size || misalign || out_of_range;
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [1:0]              lo_q, lo_d;
    logic [2:0]              size_q, size_d;
    logic                    write_q, write_d;
    logic                    hready_q, hready_d;
    logic                    hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic                    accept_s;
    logic                    addr_err_s;
    logic                    wr_fire_s;
    logic [3:0]              wr_lanes_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;
    logic [DATA_WIDTH-1:0]   fwd_word_s;
    logic                    unused_s;

    assign accept_s   = HSEL && HREADY && HTRANS[1];
    assign addr_err_s = access_err(HADDR, HSIZE);
    assign wr_fire_s  = (state_q == ST_DATA) && write_q;
    assign wr_lanes_s = lane_mask(size_q, lo_q);
    assign unused_s   = ^{HBURST, HTRANS[0]};

    // Next-state decode: a new address phase may be taken in IDLE, DATA and ERR2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    idx_d   = HADDR[IDX_W+1:2];
                    lo_d    = HADDR[1:0];
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    if (addr_err_s) begin
                        state_d = ST_ERR1;
                        cnt_d   = 4'd0;
                    end else if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DATA;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Read word for the next data phase, forwarding lanes written at this same edge.
    always_comb begin
        rd_word_s  = mem_q[idx_d];
        fwd_word_s = rd_word_s;
        for (int i = 0; i < 4; i++) begin
            if (wr_fire_s && (idx_q == idx_d) && wr_lanes_s[i]) begin
                fwd_word_s[8*i +: 8] = HWDATA[8*i +: 8];
            end else begin
                fwd_word_s[8*i +: 8] = rd_word_s[8*i +: 8];
            end
        end
    end

    // Output values for the cycle that follows, derived from the next state.
    always_comb begin
        hready_d = 1'b1;
        hresp_d  = 1'b0;
        hrdata_d = '0;
        case (state_d)
            ST_WAIT: begin
                hready_d = 1'b0;
                hresp_d  = 1'b0;
            end
            ST_DATA: begin
                hready_d = 1'b1;
                hresp_d  = 1'b0;
                if (!write_d) begin
                    hrdata_d = fwd_word_s;
                end else begin
                    hrdata_d = '0;
                end
            end
            ST_ERR1: begin
                hready_d = 1'b0;
                hresp_d  = 1'b1;
            end
            ST_ERR2: begin
                hready_d = 1'b1;
                hresp_d  = 1'b1;
            end
            default: begin
                hready_d = 1'b1;
                hresp_d  = 1'b0;
            end
        endcase
    end

    // FSM, captured address phase and registered bus outputs.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            lo_q     <= 2'b00;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Byte-lane write at the end of a write data phase; contents are never reset.
    always_ff @(posedge HCLK) begin
        if (wr_fire_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_lanes_s[i]) begin
                    mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hready_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two slaves (0 and 3 wait states) on one AHB-Lite bus,
// selected by HADDR[16]. A driver issues directed transfers and pushes the expected
// response; a negedge monitor pops and checks every data phase and idle cycle.
module tb_ahb_sram_slave;

    typedef struct {
        logic        err;
        int          w;
        logic        wr;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] hwdata = 32'h0;

    logic        ro0, ro3, rsp0, rsp3;
    logic [31:0] rd0, rd3;
    logic        dsel_q;
    logic        hready_bus, hresp_bus;
    logic [31:0] hrdata_bus;

    exp_t sb[$];
    exp_t cur;
    logic in_dp = 1'b0;
    logic nxt_dp = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    assign hready_bus = dsel_q ? ro3  : ro0;
    assign hresp_bus  = dsel_q ? rsp3 : rsp0;
    assign hrdata_bus = dsel_q ? rd3  : rd0;

    // Data-phase slave select of the interconnect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dsel_q <= 1'b0;
        else if (hready_bus) dsel_q <= haddr[16];
    end

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(bsel && !haddr[16]), .HADDR({16'h0, haddr[15:0]}),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready_bus), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rsp0));

    ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESET(rst), .HSEL(bsel && haddr[16]), .HADDR({16'h0, haddr[15:0]}),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b001), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(hready_bus), .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rsp3));

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Issue one address phase, wait until accepted, then drive its write data.
    task automatic issue(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                         input logic [1:0] tr, input logic [31:0] wd,
                         input logic err, input logic [31:0] exp_rd);
        exp_t e;
        int n;
        bsel = 1'b1; haddr = a; hwrite = wr; hsize = sz; htrans = tr;
        n = 0;
        @(negedge clk);
        while (!hready_bus && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!hready_bus) begin
            checks++; fails++;
            $display("FAIL accept_timeout actual=stalled required=ready addr=%h", a);
        end
        @(posedge clk);
        #1;
        e.err = err; e.w = a[16] ? 3 : 0; e.wr = wr; e.rd = exp_rd;
        sb.push_back(e);
        hwdata = wd;
    endtask

    task automatic idle(input int n);
        bsel = 1'b0; htrans = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: checks each data-phase cycle against the popped expectation, idle otherwise.
    initial begin
        logic        er, ep;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_dp = 1'b0; nxt_dp = 1'b0; sb.delete();
            end else begin
                if (nxt_dp) begin
                    if (sb.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL sb_empty actual=data_phase required=expectation");
                        in_dp = 1'b0;
                    end else begin
                        cur = sb.pop_front(); in_dp = 1'b1; cyc = 0;
                    end
                end
                if (in_dp) begin
                    if (cur.err) begin
                        er = (cyc != 0); ep = 1'b1; ed = 32'h0;
                    end else begin
                        er = (cyc == cur.w); ep = 1'b0;
                        ed = (er && !cur.wr) ? cur.rd : 32'h0;
                    end
                    check(cur.err ? "err_phase" : (cur.wr ? "write_phase" : "read_phase"),
                          {6'b0, hready_bus, hresp_bus, hrdata_bus}, {6'b0, er, ep, ed});
                    cyc++;
                    if (hready_bus || cyc > 40) in_dp = 1'b0;
                end else begin
                    check("idle_cycle", {6'b0, hready_bus, hresp_bus, hrdata_bus},
                          {6'b0, 1'b1, 1'b0, 32'h0});
                end
                nxt_dp = bsel && hready_bus && htrans[1];
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("reset_state", {6'b0, hready_bus, hresp_bus, hrdata_bus}, {6'b0, 1'b1, 1'b0, 32'h0});
        @(posedge clk); #1;
        // IDLE and BUSY while selected: zero-wait OKAY
        bsel = 1'b1; haddr = 32'h10; htrans = 2'b00;
        repeat (2) @(posedge clk);
        #1 htrans = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        // zero wait states: write then back-to-back read of the same word
        issue(32'h0000_0010, 1'b1, 3'd2, 2'b10, 32'hDEAD_BEEF, 1'b0, 32'h0);
        issue(32'h0000_0010, 1'b0, 3'd2, 2'b10, 32'h0,         1'b0, 32'hDEAD_BEEF);
        // lane merging: word, byte, halfword, then word read (forwarded)
        issue(32'h0000_0020, 1'b1, 3'd2, 2'b10, 32'h0000_0000, 1'b0, 32'h0);
        issue(32'h0000_0021, 1'b1, 3'd0, 2'b11, 32'h0000_AB00, 1'b0, 32'h0);
        issue(32'h0000_0022, 1'b1, 3'd1, 2'b11, 32'h1234_0000, 1'b0, 32'h0);
        issue(32'h0000_0020, 1'b0, 3'd2, 2'b11, 32'h0,         1'b0, 32'h1234_AB00);
        idle(2);
        // three wait states: write then read
        issue(32'h0001_0040, 1'b1, 3'd2, 2'b10, 32'h1111_1111, 1'b0, 32'h0);
        issue(32'h0001_0040, 1'b0, 3'd2, 2'b10, 32'h0,         1'b0, 32'h1111_1111);
        idle(2);
        // illegal accesses: misaligned halfword, past the end, oversize
        issue(32'h0000_0000, 1'b1, 3'd2, 2'b10, 32'hCAFE_F00D, 1'b0, 32'h0);
        issue(32'h0000_0001, 1'b1, 3'd1, 2'b10, 32'h5555_5555, 1'b1, 32'h0);
        issue(32'h0000_0000, 1'b0, 3'd2, 2'b10, 32'h0,         1'b0, 32'hCAFE_F00D);
        issue(32'h0000_0400, 1'b1, 3'd2, 2'b10, 32'hFFFF_FFFF, 1'b1, 32'h0);
        issue(32'h0000_0000, 1'b0, 3'd2, 2'b10, 32'h0,         1'b0, 32'hCAFE_F00D);
        issue(32'h0000_0008, 1'b0, 3'd3, 2'b10, 32'h0,         1'b1, 32'h0);
        issue(32'h0001_0003, 1'b0, 3'd1, 2'b10, 32'h0,         1'b1, 32'h0);
        issue(32'h0001_0040, 1'b0, 3'd2, 2'b10, 32'h0,         1'b0, 32'h1111_1111);
        idle(2);
        // reset during the wait of a write aborts it
        issue(32'h0001_0040, 1'b1, 3'd2, 2'b10, 32'h2222_2222, 1'b0, 32'h0);
        bsel = 1'b0; htrans = 2'b00;
        #3;
        check("wait_before_reset", {39'b0, ro3}, 40'h0);
        rst = 1'b1;
        #1;
        check("reset_async", {6'b0, ro3, rsp3, rd3}, {6'b0, 1'b1, 1'b0, 32'h0});
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        issue(32'h0001_0040, 1'b0, 3'd2, 2'b10, 32'h0, 1'b0, 32'h1111_1111);
        idle(1);
        n = 0;
        while ((sb.size() != 0 || in_dp) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0 || in_dp) begin
            checks++; fails++;
            $display("FAIL drain_timeout actual=pending required=empty");
        end
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite single-port SRAM slave; it is the DUT that the AHB verification environment's driver stimulates and whose bus activity the monitor samples. It decodes AHB-Lite address phases, holds the bus for a programmable number of wait states, performs byte/halfword/word reads and writes into an internal memory array, and signals illegal accesses with the two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 32: HADDR width.
- DATA_WIDTH, 32: HWDATA/HRDATA width; only 32 is supported.
- MEM_DEPTH, 256: number of DATA_WIDTH words; legal byte range is 0 to MEM_DEPTH*4-1.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted in every OKAY data phase (0-15).

- HCLK  in  1  bus clock; all state updates on rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  byte address.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word; larger values are illegal.
- HBURST  in  3  accepted, not used for decode.
- HTRANS  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY  in  1  bus-level ready (from the interconnect, or looped back from HREADYOUT).
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Transfer accepted when HSEL && HREADY && HTRANS[1] is high at a rising edge. At acceptance, HADDR, HWRITE and HSIZE are registered together with an error flag.
- IDLE and BUSY transfers, and any edge where HSEL is low, receive a zero-wait OKAY response: HREADYOUT=1, HRESP=0.
- HBURST is ignored. SEQ is handled exactly like NONSEQ, and each beat is independent.
- Error flag is set by any of the following:
  - HSIZE > 2.
  - Misalignment: halfword access with HADDR[0] set, or word access with HADDR[1:0] ≠ 0.
  - HADDR ≥ MEM_DEPTH*4.
- FSM states:
  - IDLE: no pending data phase. On acceptance, go to WAIT if WAIT_STATES > 0 and the access is legal; go to DATA if WAIT_STATES = 0 and the access is legal; go to ERR1 if the error flag is set.
  - WAIT: HREADYOUT=0, HRESP=0. A wait counter counts from WAIT_STATES down to 1. When the count reaches 1, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0, and the transfer completes.
    - Write: write HWDATA byte lanes into memory at this edge.
    - Read: drive HRDATA from memory.
    - Next state is IDLE. If a new transfer is accepted at the same edge, the next state follows the IDLE rules for that transfer instead (pipelined back-to-back).
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Next state follows the IDLE rules, because a new address phase can be accepted at this edge.
  - No memory access happens for an errored transfer.
- Byte lanes are little-endian. The lane enable is derived from the registered size and address:
  - Byte: lane HADDR[1:0].
  - Halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
  - Word: all four lanes.
  - Only enabled lanes are written.
- Read data: HRDATA is the full word at the registered word address, driven during the DATA cycle of a read. HRDATA is 0 in every other cycle, including writes, errors and wait cycles.
- Memory contents are not reset; read data from a location that has never been written is undefined.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Any pending address or write is discarded. Asserting reset mid-burst or mid-wait aborts the transfer immediately.
- WAIT_STATES=0: address phase at cycle T, data phase at T+1 with HREADYOUT=1. The write lands at the end of T+1.
- WAIT_STATES=W: the data phase spans W+1 cycles (W low, then 1 high).
- An error response always takes exactly 2 cycles, independent of WAIT_STATES.
- Read-after-write to the same address, back-to-back: the read's data phase returns the newly written data.
- While HREADYOUT is low, address-phase signals are not sampled, because HREADY is low.

## Test plan
- Reset release, then an IDLE transfer -> HREADYOUT=1, HRESP=0, HRDATA=0 throughout.
- WAIT_STATES=0: word write 0xDEADBEEF at 0x10, then read at 0x10 back-to-back -> read data phase returns 0xDEADBEEF with no stall.
- Write word 0x00000000 at 0x20, then byte write 0xAB at 0x21, then halfword write 0x1234 at 0x22 -> a word read at 0x20 returns 0x1234AB00.
- WAIT_STATES=3: read -> 3 cycles HREADYOUT=0, then 1 cycle HREADYOUT=1 with valid HRDATA.
- Halfword access at 0x01, then a word access at address MEM_DEPTH*4, each followed by a legal transfer:
  - Each illegal access gets a 2-cycle ERROR: (HREADYOUT=0, HRESP=1), then (HREADYOUT=1, HRESP=1).
  - Memory is unchanged.
  - The following transfer completes OKAY.
- Assert HRESET during WAIT of a write -> outputs return to reset values asynchronously, and the target word keeps its old value.
